udp_key_extractor: RTL

- Ingress tap placed directly upstream of the key comparer.
- Parses the first beat of each packet on a 512-bit AXI-Stream, extracts the 64-bit tracking key and message type, and drives the comparer's cache-key and compare-key channels.
- Forwards every packet unchanged through a one-stage register slice.
- Keeps saturating counters for short and unknown-type packets.

---
 rtl/udp_key_extractor.sv | 123 ++++++++++++
 1 files changed

// File: rtl/udp_key_extractor.sv
// Ingress tap ahead of the key comparer: forwards AXI-Stream beats through a one-stage
// slice, decodes the head beat of each packet into a cache or compare key, counts bad heads.
module udp_key_extractor #(
  parameter int         DATA_W      = 512,
  parameter int         KEY_OFFSET  = 42,
  parameter int         TYPE_OFFSET = 50,
  parameter logic [7:0] TYPE_REQ    = 8'h01,
  parameter logic [7:0] TYPE_ACK    = 8'h02,
  parameter logic [7:0] TYPE_CANCEL = 8'h03
) (
  input  logic                axis_clk,
  input  logic                axis_rstn,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                cache_key_valid,
  output logic [63:0]         cache_key,
  input  logic                cache_key_ready,
  output logic                compare_key_valid,
  output logic [63:0]         compare_key,
  output logic                compare_opcode,
  input  logic                compare_key_ready,
  output logic [31:0]         stat_short,
  output logic [31:0]         stat_unknown
);

  typedef enum logic {FIRST, BODY} state_t;

  state_t              r_state;
  logic                r_m_tvalid, r_m_tlast;
  logic [DATA_W-1:0]   r_m_tdata;
  logic [DATA_W/8-1:0] r_m_tkeep;
  logic                r_cache_v, r_cmp_v, r_cmp_op;
  logic [63:0]         r_cache_key, r_cmp_key;
  logic [31:0]         r_stat_short, r_stat_unknown;

  logic                w_slot_ok, w_ready, w_acc, w_head, w_hdr_ok;
  logic [63:0]         w_key;
  logic [7:0]          w_type;

  // Key is big-endian on the wire: lowest byte address lands in key[63:56].
  always_comb begin
    w_key = '0;
    for (int i = 0; i < 8; i++)
      w_key[63-8*i -: 8] = s_axis_tdata[8*(KEY_OFFSET+i) +: 8];
  end

  assign w_type    = s_axis_tdata[8*TYPE_OFFSET +: 8];
  assign w_hdr_ok  = &s_axis_tkeep[TYPE_OFFSET:KEY_OFFSET];
  assign w_slot_ok = !r_m_tvalid || m_axis_tready;
  // Heads wait for the key channels to drain so each packet yields at most one pending key.
  assign w_ready   = (r_state == BODY) ? w_slot_ok : (w_slot_ok && !r_cache_v && !r_cmp_v);
  assign w_acc     = s_axis_tvalid && w_ready;
  assign w_head    = w_acc && (r_state == FIRST);

  always_ff @(posedge axis_clk) begin
    if (!axis_rstn) begin
      r_state        <= FIRST;
      r_m_tvalid     <= 1'b0;
      r_m_tlast      <= 1'b0;
      r_m_tdata      <= '0;
      r_m_tkeep      <= '0;
      r_cache_v      <= 1'b0;
      r_cache_key    <= '0;
      r_cmp_v        <= 1'b0;
      r_cmp_key      <= '0;
      r_cmp_op       <= 1'b0;
      r_stat_short   <= '0;
      r_stat_unknown <= '0;
    end else begin
      if (w_slot_ok) begin
        r_m_tvalid <= w_acc;
        if (w_acc) begin
          r_m_tdata <= s_axis_tdata;
          r_m_tkeep <= s_axis_tkeep;
          r_m_tlast <= s_axis_tlast;
        end
      end

      if (w_acc)
        r_state <= s_axis_tlast ? FIRST : BODY;

      if (r_cache_v && cache_key_ready) r_cache_v <= 1'b0;
      if (r_cmp_v && compare_key_ready) r_cmp_v   <= 1'b0;

      if (w_head) begin
        if (!w_hdr_ok) begin
          if (r_stat_short != 32'hFFFF_FFFF) r_stat_short <= r_stat_short + 32'd1;
        end else if (w_type == TYPE_REQ) begin
          r_cache_v   <= 1'b1;
          r_cache_key <= w_key;
        end else if (w_type == TYPE_ACK || w_type == TYPE_CANCEL) begin
          r_cmp_v   <= 1'b1;
          r_cmp_key <= w_key;
          r_cmp_op  <= (w_type == TYPE_CANCEL);
        end else begin
          if (r_stat_unknown != 32'hFFFF_FFFF) r_stat_unknown <= r_stat_unknown + 32'd1;
        end
      end
    end
  end

  assign s_axis_tready     = w_ready;
  assign m_axis_tvalid     = r_m_tvalid;
  assign m_axis_tlast      = r_m_tlast;
  assign m_axis_tdata      = r_m_tdata;
  assign m_axis_tkeep      = r_m_tkeep;
  assign cache_key_valid   = r_cache_v;
  assign cache_key         = r_cache_key;
  assign compare_key_valid = r_cmp_v;
  assign compare_key       = r_cmp_key;
  assign compare_opcode    = r_cmp_op;
  assign stat_short        = r_stat_short;
  assign stat_unknown      = r_stat_unknown;

endmodule
